// File: rtl/dbus_req_ctrl_if.sv
// Data-bus transaction signals between the request controller and the memory side.
// Handshake: the master raises bus_valid with stable bus_* attributes and holds them
// until bus_addr_ok is seen high on a clock edge; bus_data_ok (with bus_rdata) marks
// completion of the data phase and may arrive with or after bus_addr_ok.
interface dbus_req_ctrl_if;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic [3:0]  bus_strobe;
  logic [31:0] bus_wdata;
  logic        bus_uncached;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_write, bus_size, bus_strobe, bus_wdata, bus_uncached,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_write, bus_size, bus_strobe, bus_wdata, bus_uncached,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/dbus_req_ctrl.sv
// Data-side memory request controller: MEM stage -> translator -> data bus.
// Latches one translated request, runs a valid/addr_ok/data_ok transaction,
// stalls the pipeline until completion and flags misaligned / uncached accesses.
module dbus_req_ctrl #(
  parameter logic [1:0] RESET_STATE = 2'd0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_vaddr,
  input  logic [31:0]           req_wdata,
  input  logic                  flush,
  output logic [31:0]           trans_vaddr,
  input  logic [31:0]           trans_paddr,
  dbus_req_ctrl_if.master       bus,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  addr_err,
  output logic                  exc_adel,
  output logic                  exc_ades,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        drop_q;
  logic        accept, capture, set_drop, clr_drop;
  logic        misaligned;
  logic [3:0]  strobe_n;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        write_q, uncached_q;
  logic [1:0]  size_q;
  logic [3:0]  strobe_q;

  assign trans_vaddr = req_vaddr;
  assign state_dbg   = state;

  // Alignment check and byte-enable generation from size and low address bits.
  always_comb begin
    misaligned = ((req_size == 2'd1) && req_vaddr[0]) ||
                 (req_size[1] && (req_vaddr[1:0] != 2'b00));
    case (req_size)
      2'd0:    strobe_n = 4'b0001 << req_vaddr[1:0];
      2'd1:    strobe_n = 4'b0011 << req_vaddr[1:0];
      default: strobe_n = 4'b1111;
    endcase
  end

  // Exceptions are raised only for a live (unflushed) request offered in IDLE.
  assign addr_err = (state == S_IDLE) && req_valid && !flush && misaligned;
  assign exc_adel = addr_err && !req_write;
  assign exc_ades = addr_err && req_write;

  // Next-state and handshake outputs; a dropped request still finishes on the bus
  // but returns straight to IDLE without a response.
  always_comb begin
    state_n    = state;
    stall      = 1'b0;
    bus.bus_valid = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    set_drop   = 1'b0;
    clr_drop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && !flush && !misaligned) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        bus.bus_valid = 1'b1;
        stall         = !drop_q;
        if (bus.bus_addr_ok && bus.bus_data_ok) begin
          if (drop_q || flush) begin
            clr_drop = 1'b1;
            state_n  = S_IDLE;
          end else begin
            capture = 1'b1;
            state_n = S_DONE;
          end
        end else begin
          if (bus.bus_addr_ok) state_n = S_WAIT;
          set_drop = flush;
        end
      end
      S_WAIT: begin
        stall = !drop_q;
        if (bus.bus_data_ok) begin
          if (drop_q || flush) begin
            clr_drop = 1'b1;
            state_n  = S_IDLE;
          end else begin
            capture = 1'b1;
            state_n = S_DONE;
          end
        end else begin
          set_drop = flush;
        end
      end
      S_DONE: begin
        resp_valid = !flush;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= state_t'(RESET_STATE);
    else         state <= state_n;
  end

  // Drop flag marks an in-flight transaction whose result must be discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       drop_q <= 1'b0;
    else if (clr_drop) drop_q <= 1'b0;
    else if (set_drop) drop_q <= 1'b1;
  end

  // Request attributes latched on acceptance and held for the whole transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      strobe_q   <= 4'd0;
      wdata_q    <= '0;
      uncached_q <= 1'b0;
    end else if (accept) begin
      addr_q     <= trans_paddr;
      write_q    <= req_write;
      size_q     <= req_size;
      strobe_q   <= strobe_n;
      wdata_q    <= req_wdata;
      uncached_q <= (req_vaddr[31:29] == 3'b101);
    end
  end

  // Read word captured at data_ok and held until the next capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      rdata_q <= '0;
    else if (capture) rdata_q <= bus.bus_rdata;
  end

  assign bus.bus_addr     = addr_q;
  assign bus.bus_write    = write_q;
  assign bus.bus_size     = size_q;
  assign bus.bus_strobe   = strobe_q;
  assign bus.bus_wdata    = wdata_q;
  assign bus.bus_uncached = uncached_q;
  assign resp_data        = rdata_q;

endmodule

// File: doc/dbus_req_ctrl.md
Name: dbus_req_ctrl

Overview:
- Data-side memory request controller between the MEM pipeline stage and the data bus.
- Sends the MEM-stage virtual address to the fixed-mapping address translator and takes back its physical address.
- Latches the translated request, drives a valid/addr_ok/data_ok bus transaction and stalls the pipeline until the transaction completes.
- Also checks alignment and flags kseg1 accesses as uncached.

Parameters:
- RESET_STATE, 2'd0, encoding of IDLE. Fixed; exposed only for the testbench.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- req_valid  input  1  MEM stage has a load/store
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 byte, 1 half, 2 word (3 is treated as word)
- req_vaddr  input  32  virtual address
- req_wdata  input  32  store data, already lane-positioned; passed through unmodified
- flush  input  1  squash the current request
- trans_vaddr  output  32  to the translator; equals req_vaddr
- trans_paddr  input  32  physical address from the translator (combinational)
- bus_valid  output  1  request valid
- bus_addr  output  32  latched physical address
- bus_write  output  1  latched write flag
- bus_size  output  2  latched size
- bus_strobe  output  4  byte enables
- bus_wdata  output  32  latched store data
- bus_uncached  output  1  latched: req_vaddr[31:29] == 3'b101
- bus_addr_ok  input  1  request accepted
- bus_data_ok  input  1  data phase complete
- bus_rdata  input  32  read data, valid with data_ok
- stall  output  1  freeze the pipeline
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  captured read word (raw, not shifted)
- addr_err  output  1  misaligned access (combinational)
- exc_adel  output  1  load misaligned
- exc_ades  output  1  store misaligned

Behaviour:
- Reset (async, resetn = 0): state IDLE, all registered outputs 0, drop flag 0.
- Misaligned: half with vaddr[0] = 1, or word with vaddr[1:0] != 0.
- Strobe: byte gives 4'b0001 << off; half gives 4'b0011 << off; word gives 4'b1111; off = vaddr[1:0]. Captured at latch time.
- IDLE, req_valid & !flush & aligned:
  - Latch trans_paddr, write, size, strobe, wdata, uncached.
  - Go to REQ.
  - stall = 1 combinationally this cycle.
- IDLE, req_valid & misaligned:
  - addr_err = 1; exc_adel = !req_write; exc_ades = req_write.
  - stall = 0; no bus activity; stay in IDLE.
- IDLE, !req_valid or flush: no action.
- REQ:
  - bus_valid = 1; stall = 1.
  - bus_addr_ok & bus_data_ok in the same cycle: capture rdata, go to DONE.
  - bus_addr_ok only: go to WAIT.
  - Otherwise hold every bus_* output stable.
- WAIT:
  - bus_valid = 0; stall = 1.
  - On bus_data_ok: capture rdata, go to DONE.
- DONE:
  - resp_valid = 1 and stall = 0 for exactly one cycle.
  - Then go to IDLE unconditionally; the pipeline advances at the end of DONE.
- Latency: minimum 3 cycles from IDLE acceptance to resp_valid (IDLE, REQ with both oks, DONE).
- Flush in REQ or WAIT:
  - Set the drop flag. An issued bus request is never withdrawn; bus_valid stays high in REQ until addr_ok.
  - When data_ok arrives, go to IDLE with no resp_valid and clear drop.
  - stall = 0 from the cycle after flush.
- Flush in DONE: suppress resp_valid; go to IDLE.
- resp_data holds its value until the next capture.
- bus_data_ok outside REQ/WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE; outputs cleared.

Test Plan:
- Load word, vaddr 0x8000_1004, addr_ok and data_ok in the same cycle, rdata 0xDEADBEEF -> bus_addr 0x0000_1004, uncached 0, strobe 4'hF, resp_valid one cycle later with data 0xDEADBEEF, stall low only in DONE.
- Store byte, vaddr 0xA000_0013, data_ok 4 cycles after addr_ok -> bus_addr 0x0000_0013, uncached 1, strobe 4'b1000, bus_valid low in WAIT, stall for 6 cycles.
- Load half at 0x8000_0001 -> addr_err = 1, exc_adel = 1, no bus_valid, stall 0; store word at 0x8000_0002 -> exc_ades = 1.
- addr_ok withheld 5 cycles in REQ -> bus_* stable; flush raised in cycle 2 -> bus_valid held until addr_ok, no resp_valid, returns to IDLE after data_ok.
- resetn pulsed low during WAIT -> state IDLE, bus_valid, stall and resp_valid all 0 asynchronously; a new request is accepted right after reset release.
